// File: rtl/logic_unit_arbiter_if.sv
// Request/result bundle between the requesting engines and the shared
// bitwise logic unit. The engines act as master, the arbiter as slave.
interface logic_unit_arbiter_if #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]       req;
    logic [2*NUM_REQ-1:0]     op;
    logic [WIDTH*NUM_REQ-1:0] A;
    logic [WIDTH*NUM_REQ-1:0] B;
    logic [NUM_REQ-1:0]       gnt;
    logic [WIDTH-1:0]         Y;
    logic                     y_valid;
    logic [IDW-1:0]           y_id;
    logic                     y_ready;
    logic                     busy;

    modport master (
        output req, op, A, B, y_ready,
        input  gnt, Y, y_valid, y_id, busy
    );

    modport slave (
        input  req, op, A, B, y_ready,
        output gnt, Y, y_valid, y_id, busy
    );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter in front of a shared AND/OR/XOR/NOT datapath.
// One operation at a time: IDLE picks a winner and latches its operands,
// EXEC computes the registered result, RESP holds it until accepted.
module logic_unit_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    logic_unit_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [IDW-1:0]     ptr_reg, ptr_next;
    logic [IDW-1:0]     win_reg, win_next;
    logic [1:0]         op_lat_reg, op_lat_next;
    logic [WIDTH-1:0]   a_lat_reg, a_lat_next;
    logic [WIDTH-1:0]   b_lat_reg, b_lat_next;
    logic [NUM_REQ-1:0] gnt_reg, gnt_next;
    logic [WIDTH-1:0]   y_reg, y_next;
    logic               y_valid_reg, y_valid_next;
    logic [IDW-1:0]     y_id_reg, y_id_next;

    // Per-requester views of the packed operand buses.
    logic [1:0]       op_arr [NUM_REQ];
    logic [WIDTH-1:0] a_arr  [NUM_REQ];
    logic [WIDTH-1:0] b_arr  [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign op_arr[gi] = bus.op[2*gi +: 2];
            assign a_arr[gi]  = bus.A[WIDTH*gi +: WIDTH];
            assign b_arr[gi]  = bus.B[WIDTH*gi +: WIDTH];
        end
    endgenerate

    // Bit-sliced gate datapath working only on the latched operands.
    logic [WIDTH-1:0] and_v, or_v, xor_v, not_v, f_v;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_gates
            assign and_v[gi] = a_lat_reg[gi] & b_lat_reg[gi];
            assign or_v[gi]  = a_lat_reg[gi] | b_lat_reg[gi];
            assign xor_v[gi] = a_lat_reg[gi] ^ b_lat_reg[gi];
            assign not_v[gi] = ~a_lat_reg[gi];
        end
    endgenerate

    // Opcode select among the gate outputs.
    always_comb begin
        f_v = and_v;
        unique case (op_lat_reg)
            2'b00: f_v = and_v;
            2'b01: f_v = or_v;
            2'b10: f_v = xor_v;
            2'b11: f_v = not_v;
            default: f_v = and_v;
        endcase
    end

    // Round-robin search: first active request at or above ptr, wrapping to 0.
    logic           pick_found;
    logic [IDW-1:0] pick_idx;
    always_comb begin
        int             idx;
        logic [IDW-1:0] cand;
        pick_found = 1'b0;
        pick_idx   = ptr_reg;
        idx        = 0;
        cand       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = IDW'(idx);
            if (!pick_found && bus.req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state and registered-output logic; everything holds by default.
    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        win_next     = win_reg;
        op_lat_next  = op_lat_reg;
        a_lat_next   = a_lat_reg;
        b_lat_next   = b_lat_reg;
        gnt_next     = gnt_reg;
        y_next       = y_reg;
        y_valid_next = y_valid_reg;
        y_id_next    = y_id_reg;
        unique case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    win_next           = pick_idx;
                    op_lat_next        = op_arr[pick_idx];
                    a_lat_next         = a_arr[pick_idx];
                    b_lat_next         = b_arr[pick_idx];
                    gnt_next           = '0;
                    gnt_next[pick_idx] = 1'b1;
                    state_next         = EXEC;
                end
            end
            EXEC: begin
                y_next       = f_v;
                y_id_next    = win_reg;
                y_valid_next = 1'b1;
                gnt_next     = '0;
                ptr_next     = (win_reg == IDW'(NUM_REQ - 1)) ? '0 : win_reg + IDW'(1);
                state_next   = RESP;
            end
            RESP: begin
                if (bus.y_ready) begin
                    y_valid_next = 1'b0;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            win_reg     <= '0;
            op_lat_reg  <= '0;
            a_lat_reg   <= '0;
            b_lat_reg   <= '0;
            gnt_reg     <= '0;
            y_reg       <= '0;
            y_valid_reg <= 1'b0;
            y_id_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            win_reg     <= win_next;
            op_lat_reg  <= op_lat_next;
            a_lat_reg   <= a_lat_next;
            b_lat_reg   <= b_lat_next;
            gnt_reg     <= gnt_next;
            y_reg       <= y_next;
            y_valid_reg <= y_valid_next;
            y_id_reg    <= y_id_next;
        end
    end

    assign bus.gnt     = gnt_reg;
    assign bus.Y       = y_reg;
    assign bus.y_valid = y_valid_reg;
    assign bus.y_id    = y_id_reg;
    assign bus.busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench for logic_unit_arbiter: directed scenarios plus randomized requesters,
// all checked every cycle against a transaction-level reference model.
module tb_logic_unit_arbiter;
    localparam int WIDTH   = 8;
    localparam int NUM_REQ = 4;
    localparam int IDW     = 2;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic_unit_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .IDW(IDW)) bus ();

    logic_unit_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Requester-side stimulus state.
    logic [NUM_REQ-1:0] r_req;
    logic [1:0]         r_op [NUM_REQ];
    logic [WIDTH-1:0]   r_a  [NUM_REQ];
    logic [WIDTH-1:0]   r_b  [NUM_REQ];
    logic               r_ready;

    // Reference model: expected outputs after the coming edge.
    logic [NUM_REQ-1:0] exp_gnt;
    logic [WIDTH-1:0]   exp_Y;
    logic               exp_y_valid;
    logic [IDW-1:0]     exp_y_id;
    logic               exp_busy;
    bit                 m_captured;   // operation accepted, result not yet produced
    bit                 m_presented;  // result shown, awaiting acceptance
    int                 m_start;      // first index to consider in the next search
    int                 m_id;
    logic [1:0]         m_op;
    logic [WIDTH-1:0]   m_a, m_b;
    int                 txn_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, req_v, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] logic_fn(input logic [1:0] o,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        case (o)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~a;
        endcase
    endfunction

    task automatic model_reset();
        m_captured  = 1'b0;
        m_presented = 1'b0;
        m_start     = 0;
        exp_gnt     = '0;
        exp_Y       = '0;
        exp_y_valid = 1'b0;
        exp_y_id    = '0;
        exp_busy    = 1'b0;
    endtask

    // Advance the model by one edge using the inputs just driven.
    task automatic model_edge();
        int             w;
        int             c;
        logic [IDW-1:0] wi;
        if (!rst_n) begin
            model_reset();
        end else begin
            exp_gnt = '0;
            if (m_captured) begin
                exp_Y       = logic_fn(m_op, m_a, m_b);
                exp_y_id    = IDW'(m_id);
                exp_y_valid = 1'b1;
                m_captured  = 1'b0;
                m_presented = 1'b1;
                m_start     = (m_id + 1) % NUM_REQ;
            end else if (m_presented) begin
                if (r_ready) begin
                    txn_count++;
                    $display("TXN %0d: id=%0d op=%0d A=0x%02h B=0x%02h Y=0x%02h",
                             txn_count, m_id, m_op, m_a, m_b, exp_Y);
                    exp_y_valid = 1'b0;
                    m_presented = 1'b0;
                end
            end else begin
                w = -1;
                for (int k = 0; k < NUM_REQ; k++) begin
                    c = (m_start + k) % NUM_REQ;
                    if (w < 0 && r_req[c[IDW-1:0]]) w = c;
                end
                if (w >= 0) begin
                    wi         = w[IDW-1:0];
                    m_id       = w;
                    m_op       = r_op[wi];
                    m_a        = r_a[wi];
                    m_b        = r_b[wi];
                    exp_gnt    = NUM_REQ'(1 << w);
                    m_captured = 1'b1;
                end
            end
            exp_busy = m_captured || m_presented;
        end
    endtask

    task automatic apply();
        bus.req     = r_req;
        bus.y_ready = r_ready;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.op[2*i +: 2]     = r_op[i];
            bus.A[WIDTH*i +: WIDTH] = r_a[i];
            bus.B[WIDTH*i +: WIDTH] = r_b[i];
        end
    endtask

    task automatic commit(input logic [NUM_REQ-1:0] rq, input logic rdy);
        r_req   = rq;
        r_ready = rdy;
        apply();
        model_edge();
    endtask

    task automatic cyc(input logic [NUM_REQ-1:0] rq, input logic rdy);
        @(negedge clk);
        commit(rq, rdy);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic set_op(input int i, input logic [1:0] o, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b);
        r_op[i] = o;
        r_a[i]  = a;
        r_b[i]  = b;
    endtask

    task automatic rand_op(input int i);
        r_op[i] = 2'($urandom_range(0, 3));
        r_a[i]  = WIDTH'($urandom);
        r_b[i]  = WIDTH'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},     32'(bus.gnt),     32'h0);
        check({tag, "_y_valid"}, 32'(bus.y_valid), 32'h0);
        check({tag, "_Y"},       32'(bus.Y),       32'h0);
        check({tag, "_y_id"},    32'(bus.y_id),    32'h0);
        check({tag, "_busy"},    32'(bus.busy),    32'h0);
    endtask

    // Single-requester operation with a hand-computed result.
    task automatic run_op(input int i, input logic [1:0] o, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] y_lit);
        set_op(i, o, a, b);
        cyc(NUM_REQ'(1 << i), 1'b1);
        cyc('0, 1'b1);
        settle();
        check("op_Y", 32'(bus.Y), 32'(y_lit));
        check("op_y_id", 32'(bus.y_id), 32'(i));
        check("op_model_Y", 32'(exp_Y), 32'(y_lit));
        cyc('0, 1'b1);
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(posedge clk) begin
        #2;
        check("cmp_gnt",     32'(bus.gnt),     32'(exp_gnt));
        check("cmp_y_valid", 32'(bus.y_valid), 32'(exp_y_valid));
        check("cmp_busy",    32'(bus.busy),    32'(exp_busy));
        check("cmp_Y",       32'(bus.Y),       32'(exp_Y));
        check("cmp_y_id",    32'(bus.y_id),    32'(exp_y_id));
    end

    int g_val[$];
    int g_at[$];
    int v_id[$];
    int exp_g[5]  = '{1, 2, 4, 8, 1};
    int exp_id[5] = '{0, 1, 2, 3, 0};

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_op(i, 2'b00, '0, '0);
        model_reset();
        r_req   = '0;
        r_ready = 1'b0;
        apply();

        // Reset state.
        cyc('0, 1'b0);
        cyc('0, 1'b0);
        settle();
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        commit('0, 1'b1);

        // Single AND on requester 0.
        set_op(0, 2'b00, 8'hF0, 8'h3C);
        cyc(4'b0001, 1'b1);
        settle();
        check("and_gnt", 32'(bus.gnt), 32'h1);
        check("and_busy", 32'(bus.busy), 32'h1);
        check("and_valid_early", 32'(bus.y_valid), 32'h0);
        cyc('0, 1'b1);
        settle();
        check("and_valid", 32'(bus.y_valid), 32'h1);
        check("and_Y", 32'(bus.Y), 32'h30);
        check("and_y_id", 32'(bus.y_id), 32'h0);
        check("and_gnt_off", 32'(bus.gnt), 32'h0);
        cyc('0, 1'b1);
        settle();
        check("and_valid_drop", 32'(bus.y_valid), 32'h0);
        check("and_idle", 32'(bus.busy), 32'h0);

        // Remaining opcodes through requester 2.
        run_op(2, 2'b01, 8'hF0, 8'h0F, 8'hFF);
        run_op(2, 2'b10, 8'hAA, 8'hFF, 8'h55);
        run_op(2, 2'b11, 8'h0F, 8'hAA, 8'hF0);

        // Reset during EXEC discards the operation.
        set_op(0, 2'b01, 8'h11, 8'h22);
        cyc(4'b0001, 1'b1);
        settle();
        check("rst_pre_gnt", 32'(bus.gnt), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all_zero("rst_mid");
        cyc('0, 1'b1);
        cyc('0, 1'b1);

        // Round robin with all requesters held; first grant shows ptr restarted at 0.
        set_op(0, 2'b00, 8'hFF, 8'h5A);
        set_op(1, 2'b01, 8'h01, 8'h80);
        set_op(2, 2'b10, 8'h0F, 8'h3C);
        set_op(3, 2'b11, 8'hC3, 8'h00);
        for (int k = 1; k <= 15; k++) begin
            if (k == 1) begin
                @(negedge clk);
                rst_n = 1'b1;
                commit(4'b1111, 1'b1);
            end else begin
                cyc(4'b1111, 1'b1);
            end
            settle();
            if (k <= 2) check("rr_no_stale_valid", 32'(bus.y_valid), 32'(k == 2));
            if (bus.gnt != '0) begin
                g_val.push_back(int'(bus.gnt));
                g_at.push_back(k);
            end
            if (bus.y_valid) v_id.push_back(int'(bus.y_id));
        end
        check("rr_grant_count", 32'(g_val.size()), 32'd5);
        check("rr_valid_count", 32'(v_id.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < g_val.size()) begin
                check("rr_gnt", 32'(g_val[i]), 32'(exp_g[i]));
                check("rr_gnt_cycle", 32'(g_at[i]), 32'(1 + 3 * i));
            end
            if (i < v_id.size()) check("rr_y_id", 32'(v_id[i]), 32'(exp_id[i]));
        end

        // Pointer wrap and skip.
        cyc(4'b0010, 1'b1);
        settle();
        check("wrap_gnt1", 32'(bus.gnt), 32'h2);
        cyc('0, 1'b1);
        cyc('0, 1'b1);
        cyc(4'b0011, 1'b1);
        settle();
        check("wrap_gnt_after1", 32'(bus.gnt), 32'h1);
        cyc('0, 1'b1);
        cyc('0, 1'b1);
        cyc(4'b1000, 1'b1);
        settle();
        check("wrap_gnt3", 32'(bus.gnt), 32'h8);
        cyc('0, 1'b1);
        cyc('0, 1'b1);
        cyc(4'b1000, 1'b1);
        settle();
        check("wrap_gnt_after3", 32'(bus.gnt), 32'h8);
        cyc('0, 1'b1);
        cyc('0, 1'b1);

        // Backpressure: result held while others request.
        set_op(0, 2'b01, 8'h12, 8'h40);
        set_op(1, 2'b00, 8'h33, 8'h0F);
        set_op(2, 2'b10, 8'h77, 8'h70);
        cyc(4'b0001, 1'b0);
        cyc(4'b0110, 1'b0);
        settle();
        for (int s = 0; s < 5; s++) begin
            cyc(4'b0110, 1'b0);
            settle();
            check("bp_valid", 32'(bus.y_valid), 32'h1);
            check("bp_Y", 32'(bus.Y), 32'h52);
            check("bp_y_id", 32'(bus.y_id), 32'h0);
            check("bp_gnt", 32'(bus.gnt), 32'h0);
            check("bp_busy", 32'(bus.busy), 32'h1);
        end
        cyc(4'b0110, 1'b1);
        settle();
        check("bp_release_valid", 32'(bus.y_valid), 32'h0);
        check("bp_release_gnt", 32'(bus.gnt), 32'h0);
        cyc(4'b0110, 1'b1);
        settle();
        check("bp_next_gnt", 32'(bus.gnt), 32'h2);
        cyc(4'b0100, 1'b1);
        cyc(4'b0100, 1'b1);
        cyc(4'b0100, 1'b1);
        cyc('0, 1'b1);
        cyc('0, 1'b1);
        cyc('0, 1'b1);

        // Randomized requesters, including one asynchronous reset mid-stream.
        for (int n = 0; n < 2000; n++) begin
            if (n == 700) begin
                @(posedge clk);
                #3;
                rst_n = 1'b0;
                model_reset();
                #1;
                check_all_zero("rand_rst");
            end
            @(negedge clk);
            if (n == 703) rst_n = 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (r_req[i] && exp_gnt[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        rand_op(i);
                    end else begin
                        r_req[i] = 1'b0;
                        rand_op(i);
                    end
                end else if (!r_req[i] && $urandom_range(0, 3) == 0) begin
                    rand_op(i);
                    r_req[i] = 1'b1;
                end
            end
            r_ready = ($urandom_range(0, 9) < 7);
            apply();
            model_edge();
        end
        cyc('0, 1'b1);
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Shares one bitwise logic unit (AND, OR, XOR, NOT, built from the team's AND_gate/OR_gate/XOR_gate/NOT_gate cells) between NUM_REQ requesters. Arbitration is round-robin. Each request is a single operation with operands A, B and a 2-bit opcode. The block latches the winner's operands, executes, and returns a registered result with the winner's index over a valid/ready handshake. It sits between the requesting engines and the shared gate datapath, and is the only path into that datapath.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits
- NUM_REQ, 4, number of requesters (≥2)
- IDW, $clog2(NUM_REQ), width of requester index

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  per-requester request, level
- op  in  2*NUM_REQ  opcode of requester i at [2i+1:2i]
- A  in  WIDTH*NUM_REQ  operand A of requester i at [WIDTH*i +: WIDTH]
- B  in  WIDTH*NUM_REQ  operand B of requester i, same packing
- gnt  out  NUM_REQ  one-hot grant; operands were captured
- Y  out  WIDTH  result
- y_valid  out  1  result valid
- y_id  out  IDW  index of requester owning Y
- y_ready  in  1  consumer accepts result
- busy  out  1  high whenever state ≠ IDLE

## Operation
- Opcodes: 00 Y=A&B; 01 Y=A|B; 10 Y=A^B; 11 Y=~A (B ignored).
- The FSM has three states: IDLE, EXEC, RESP.
- IDLE, req≠0 at the edge:
  - Select the winner by searching from ptr upward, wrapping at NUM_REQ-1→0.
  - Latch the winner's op/A/B and index.
  - gnt<=onehot(winner); go to EXEC.
- IDLE, req=0: stay in IDLE; outputs unchanged.
- EXEC, next edge:
  - Y<=f(latched op,A,B); y_id<=winner; y_valid<=1; gnt<=0.
  - ptr<=(winner+1) mod NUM_REQ; go to RESP.
- RESP:
  - Hold Y, y_id and y_valid stable.
  - At an edge with y_ready=1: y_valid<=0; go to IDLE.
  - No arbitration is performed in RESP.
- Requester rules:
  - Hold req, op, A and B stable until gnt is seen high.
  - Drop req the cycle after gnt, unless issuing a new operation.
- Operands are latched, so input changes after capture never affect Y.
- A req still high after gnt is treated as a new request at the next IDLE.
- Reset:
  - rst_n low at any time forces state=IDLE, ptr=0, and gnt=0, Y=0, y_valid=0, y_id=0, busy=0 immediately (asynchronous).
  - An in-flight operation is discarded; no y_valid follows.
  - Release is synchronous to clk; the first arbitration happens at the first edge with rst_n high.

## Timing
- Edge 0 samples req in IDLE.
- Cycle 1 (after edge 0): gnt high, busy high.
- Cycle 2 (after edge 1): y_valid high with the result.
- Latency: req to y_valid is 2 edges.
- gnt is high for exactly one cycle per operation.
- If y_ready=1 when y_valid rises, y_valid drops after edge 2 and state is IDLE in cycle 3.
- Next arbitration happens at edge 3, so the next gnt appears in cycle 4.
- Peak throughput: one operation per 3 cycles.
- y_ready=0 stalls in RESP indefinitely with outputs stable; other requests wait.
- Requests rising while busy are only considered at the next IDLE edge.
- The pointer search always starts at the index after the last winner, so no requester waits more than NUM_REQ-1 operations.

## Test plan
- Reset mid-op: start an op, then drop rst_n during EXEC → gnt, y_valid, Y, y_id and busy are 0 immediately. After release, no stale y_valid appears; ptr=0 (req=1111 grants 0001 first).
- Single AND: req=0001, op0=00, A0=0xF0, B0=0x3C, y_ready=1 → gnt=0001 in cycle 1; cycle 2 shows y_valid=1, Y=0x30, y_id=0.
- All opcodes via requester 2 (WIDTH=8), results in order:
  - OR 0xF0,0x0F → 0xFF
  - XOR 0xAA,0xFF → 0x55
  - NOT A=0x0F, B=0xAA → 0xF0
  - Each result has y_id=2.
- Round-robin: req=1111 held, y_ready=1 → grants 0001, 0010, 0100, 1000, 0001, spaced 3 cycles apart; y_id sequence 0, 1, 2, 3, 0.
- Pointer wrap/skip: after a grant to requester 1, apply req=0011 → the search order is 2, 3, 0, so the grant is 0001. After a grant to requester 3, apply req=1000 → the grant is 1000.
- Backpressure: result pending with y_ready=0 for 5 cycles, req=0110 asserted → Y, y_id and y_valid stay stable and gnt stays 0. Raising y_ready → y_valid drops, and the next gnt follows 2 cycles later per the ptr order.
